row_clear_engine: RTL and testbench

- Parametrised successor to the combinational full-row detector; holds a ROWS x COLS occupancy grid in registers.
- Detects full rows and iteratively clears them, one per operation, topmost first, collapsing the rows above downward (falling-block line clear).
- Sits between the playfield update logic, which loads the grid, and the score/display logic, which reads the grid, count and flags.
- Keeps a combinational one-hot "first full row" output whose encoding matches the legacy 3-bit detector when ROWS=3 and COLS=4.

---
 rtl/row_clear_if.sv | 26 ++
 rtl/row_clear_engine.sv | 115 +++++++++++
 tb/tb_row_clear_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/row_clear_if.sv
// Playfield-side bundle for row_clear_engine: grid load, start request, and grid/count/flag readback.
interface row_clear_if #(
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int CW   = $clog2(ROWS + 1)
) ();
  logic                 load;
  logic [ROWS*COLS-1:0] din;
  logic                 start;
  logic [ROWS*COLS-1:0] grid;
  logic [ROWS-1:0]      full_flags;
  logic [ROWS-1:0]      first_full;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        cleared_count;

  modport master (
    output load, din, start,
    input  grid, full_flags, first_full, busy, done, cleared_count
  );

  modport slave (
    input  load, din, start,
    output grid, full_flags, first_full, busy, done, cleared_count
  );
endinterface

// File: rtl/row_clear_engine.sv
// Registered ROWS x COLS occupancy grid with an iterative full-row clear (one row per SCAN/CLEAR pair).
// Handshake: load/start are sampled only while busy=0; load has priority over start; start acts as a
// request accepted on that edge, and the sequence ends with a single-cycle done pulse.
module row_clear_engine #(
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int CW   = $clog2(ROWS + 1)
) (
  input  logic        clk,
  input  logic        reset,
  row_clear_if.slave  bus,
  output logic [1:0]  state_dbg
);
  localparam int W  = ROWS * COLS;
  localparam int KW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, CLEAR = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    grid_q;
  logic [W-1:0]    shifted;
  logic [CW-1:0]   count_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   first_idx;
  logic [ROWS-1:0] full;
  logic [ROWS-1:0] first;
  logic            busy;
  logic            done;

  // Row r lives in bits [(ROWS-r)*COLS-1 -: COLS], so row 0 sits in the MSBs.
  always_comb begin
    full = '0;
    for (int r = 0; r < ROWS; r++) begin
      full[r] = &grid_q[(ROWS-r)*COLS-1 -: COLS];
    end
  end

  // Lowest set bit isolation gives the topmost full row as a one-hot.
  assign first = full & (~full + ROWS'(1));

  always_comb begin
    first_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (full[r]) first_idx = KW'(r);
    end
  end

  // Remove row k: everything above drops one row, row 0 becomes empty.
  always_comb begin
    shifted = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(k_q))
        shifted[(ROWS-r)*COLS-1 -: COLS] = grid_q[(ROWS-r+1)*COLS-1 -: COLS];
      else
        shifted[(ROWS-r)*COLS-1 -: COLS] = grid_q[(ROWS-r)*COLS-1 -: COLS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.load && bus.start) state_d = SCAN;
      SCAN:    state_d = (|full) ? CLEAR : DONE;
      CLEAR:   state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      SCAN:    busy = 1'b1;
      CLEAR:   busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load)       grid_q  <= bus.din;
          else if (bus.start) count_q <= '0;
        end
        SCAN:  if (|full) k_q <= first_idx;
        CLEAR: begin
          grid_q  <= shifted;
          count_q <= count_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.grid          = grid_q;
  assign bus.full_flags    = full;
  assign bus.first_full    = first;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.cleared_count = count_q;
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_row_clear_engine.sv
// Scoreboard bench for row_clear_engine: directed cases plus randomized grids against a row-list model.
module tb_row_clear_engine;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int W    = ROWS * COLS;
  localparam int CW   = $clog2(ROWS + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         busy_run = 0;
  logic [W-1:0] cur_grid;

  logic [W-1:0] exp_q[$];
  int           exp_n_q[$];
  int           exp_cyc_q[$];

  row_clear_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  row_clear_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [ROWS-1:0] model_full(input logic [W-1:0] g);
    logic [ROWS-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++)
      f[r] = (g[(ROWS-r)*COLS-1 -: COLS] == {COLS{1'b1}});
    return f;
  endfunction

  function automatic logic [ROWS-1:0] model_first(input logic [W-1:0] g);
    logic [ROWS-1:0] f;
    logic [ROWS-1:0] o;
    f = model_full(g);
    o = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (f[r]) begin
        o[r] = 1'b1;
        break;
      end
    end
    return o;
  endfunction

  function automatic void model_clear(input logic [W-1:0] g, output logic [W-1:0] fin, output int n);
    logic [COLS-1:0] rq[$];
    int idx;
    for (int r = 0; r < ROWS; r++) rq.push_back(g[(ROWS-r)*COLS-1 -: COLS]);
    n = 0;
    forever begin
      idx = -1;
      for (int r = 0; r < ROWS; r++) begin
        if (rq[r] == {COLS{1'b1}}) begin
          idx = r;
          break;
        end
      end
      if (idx < 0) break;
      rq.delete(idx);
      rq.push_front('0);
      n++;
    end
    fin = '0;
    for (int r = 0; r < ROWS; r++) fin[(ROWS-r)*COLS-1 -: COLS] = rq[r];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] eg;
    int en, ec;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.busy) busy_run++;
        else busy_run = 0;
        chk("full_flags", bus.full_flags, model_full(bus.grid));
        chk("first_full", bus.first_full, model_first(bus.grid));
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            eg = exp_q.pop_front();
            en = exp_n_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("final_grid", bus.grid, eg);
            chk("cleared_count", bus.cleared_count, en);
            chk("done_latency", cyc, ec);
            chk("busy_len", busy_run, 2 * en + 2);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [W-1:0] d);
    @(negedge clk);
    bus.load = 1'b1;
    bus.din  = d;
    @(negedge clk);
    bus.load = 1'b0;
    #1;
    chk("load_grid", bus.grid, d);
    cur_grid = d;
  endtask

  task automatic do_start(input bit junk);
    logic [W-1:0] fin;
    int n;
    int i;
    model_clear(cur_grid, fin, n);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(fin);
    exp_n_q.push_back(n);
    exp_cyc_q.push_back(cyc + 2 * n + 1);
    @(negedge clk);
    bus.start = 1'b0;
    if (junk) begin
      for (int j = 0; j < 2 * n + 1; j++) begin
        bus.load  = 1'b1;
        bus.start = 1'b1;
        bus.din   = W'($urandom);
        @(negedge clk);
      end
      bus.load  = 1'b0;
      bus.start = 1'b0;
    end
    for (i = 0; i < 4 * ROWS + 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      exp_n_q.delete();
      exp_cyc_q.delete();
    end
    cur_grid = fin;
    repeat (2) @(negedge clk);
    chk("count_hold", bus.cleared_count, n);
    chk("idle_busy", bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.din   = '0;
    cur_grid  = '0;
    repeat (2) @(negedge clk);
    chk("rst_grid", bus.grid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_count", bus.cleared_count, 0);
    reset = 1'b0;

    do_load(12'h3F7);
    chk("ff_3F7", bus.full_flags, 3'b010);
    chk("first_3F7", bus.first_full, 3'b010);
    do_start(1'b0);
    do_load(12'hF0F);
    do_start(1'b0);
    do_load(12'hFFF);
    chk("first_FFF", bus.first_full, 3'b001);
    do_start(1'b0);
    do_load(12'h123);
    chk("ff_123", bus.full_flags, 3'b000);
    do_start(1'b0);
    do_load(12'h3F7);
    do_start(1'b1);

    // load and start together in IDLE: load wins
    @(negedge clk);
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.din   = 12'h0F0;
    @(posedge clk);
    #1;
    chk("ls_busy", bus.busy, 0);
    chk("ls_grid", bus.grid, 12'h0F0);
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ls_idle", bus.busy, 0);
    end
    cur_grid = 12'h0F0;

    // reset during the first CLEAR cycle of a full-grid clear
    do_load(12'hFFF);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_in_clear", state_dbg, 2'd2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_grid", bus.grid, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_count", bus.cleared_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    cur_grid = '0;

    // randomized grids, biased toward full rows
    for (int t = 0; t < 40; t++) begin
      d = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 1) == 1) d[(ROWS-r)*COLS-1 -: COLS] = {COLS{1'b1}};
        else                           d[(ROWS-r)*COLS-1 -: COLS] = COLS'($urandom);
      end
      do_load(d);
      do_start($urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
